fifo_wr_arb: RTL and testbench

Round-robin write arbiter that shares the single write port of the team's synchronous FIFO among `NUM_REQ` producers. Each cycle it selects at most one requesting producer, forwards that producer's data word and a write strobe to the FIFO, and returns a one-hot grant that marks the beat as accepted. It sits directly in front of the FIFO write side, and gates every grant on the FIFO `full` flag.

---
 rtl/fifo_wr_arb.sv | 157 +++++++++++++++
 tb/tb_fifo_wr_arb.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter for the single write port of the synchronous
// FIFO. It grants at most one requesting producer per cycle, never while the
// FIFO is full, and forwards that producer's word with the write strobe.
// Optional burst lock: define FIFO_ARB_LOCK_EN so that a granted producer keeps
// the port for up to BURST_LEN consecutive beats. Without the macro, every beat
// is re-arbitrated and busy is tied low.
module fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [IW-1:0]                 grant_id,
  output logic                          fifo_write_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic                          busy
);

  // Index that follows i in round-robin order, wrapping at NUM_REQ.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  logic [IW-1:0] rr_ptr_reg;
  logic [IW-1:0] scan_base;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic          lock_hold;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic [FIFO_WIDTH-1:0] masked [NUM_REQ];
  logic [FIFO_WIDTH-1:0] data_or;

`ifdef FIFO_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCK} state_t;
  state_t        state_reg;
  logic [IW-1:0] owner_reg;
  logic [7:0]    beat_cnt_reg;
  logic          busy_reg;

  // In LOCK the owner keeps the port while it requests; when it drops its
  // request the port is re-arbitrated in the same cycle starting after it.
  always_comb begin
    lock_hold = (state_reg == LOCK) && req[owner_reg];
    scan_base = (state_reg == LOCK) ? next_idx(owner_reg) : rr_ptr_reg;
  end

  assign busy = busy_reg;
`else
  assign lock_hold = 1'b0;
  assign scan_base = rr_ptr_reg;
  assign busy      = 1'b0;
`endif

  // Round-robin search: first requester at or after scan_base, wrapping.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(scan_base) + k) % NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  // A beat is issued only out of reset and into a non-full FIFO.
  always_comb begin
    grant_idx   = lock_hold ? scan_base - scan_base + owner_sel() : win_idx;
    grant_valid = resetN && !fifo_full && (lock_hold || win_found);
  end

  // Owner index when locked; zero in the unlocked build (never selected there).
  function automatic logic [IW-1:0] owner_sel();
`ifdef FIFO_ARB_LOCK_EN
    return owner_reg;
`else
    return '0;
`endif
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign gnt[gi]    = grant_valid && (int'(grant_idx) == gi);
      assign masked[gi] = gnt[gi] ? req_data[gi*FIFO_WIDTH +: FIFO_WIDTH] : '0;
    end
  endgenerate

  // AND-OR data mux: only the granted lane is non-zero.
  always_comb begin
    data_or = '0;
    for (int k = 0; k < NUM_REQ; k++) data_or = data_or | masked[k];
  end

  assign fifo_data_in  = data_or;
  assign fifo_write_en = grant_valid;
  assign grant_id      = grant_valid ? grant_idx : '0;

`ifdef FIFO_ARB_LOCK_EN
  // Burst-lock state machine; rr_ptr moves only when a producer gives up the port.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      owner_reg    <= '0;
      beat_cnt_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      if (state_reg == LOCK && !req[owner_reg]) begin
        rr_ptr_reg <= next_idx(owner_reg);
      end
      if (lock_hold) begin
        if (grant_valid) begin
          if (beat_cnt_reg + 8'd1 == 8'(BURST_LEN)) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            beat_cnt_reg <= '0;
            rr_ptr_reg   <= next_idx(owner_reg);
          end else begin
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
          end
        end
      end else if (grant_valid && BURST_LEN > 1) begin
        state_reg    <= LOCK;
        busy_reg     <= 1'b1;
        owner_reg    <= grant_idx;
        beat_cnt_reg <= 8'd1;
      end else begin
        if (grant_valid) rr_ptr_reg <= next_idx(grant_idx);
        state_reg    <= IDLE;
        busy_reg     <= 1'b0;
        beat_cnt_reg <= '0;
      end
    end
  end
`else
  // Single-beat round robin: advance past every granted producer.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rr_ptr_reg <= '0;
    end else if (grant_valid) begin
      rr_ptr_reg <= next_idx(grant_idx);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed testbench for fifo_wr_arb (NUM_REQ=4, FIFO_WIDTH=8, BURST_LEN=4).
// Producer i always offers word 8'hA0+i. Lock scenarios run when the bench is
// built with FIFO_ARB_LOCK_EN, single-beat scenarios otherwise.
module tb_fifo_wr_arb;
  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [3:0]  req = 4'b1111;
  logic [31:0] req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  logic        fifo_full = 1'b0;
  logic [3:0]  gnt;
  logic [1:0]  grant_id;
  logic        fifo_write_en;
  logic [7:0]  fifo_data_in;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  fifo_wr_arb #(.NUM_REQ(4), .FIFO_WIDTH(8), .BURST_LEN(4)) dut (
    .clk(clk), .resetN(resetN), .req(req), .req_data(req_data),
    .fifo_full(fifo_full), .gnt(gnt), .grant_id(grant_id),
    .fifo_write_en(fifo_write_en), .fifo_data_in(fifo_data_in), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the combinational beat at the
  // negative edge, then let it commit. exp_id < 0 means no grant expected.
  task automatic cycle(input logic [3:0] r, input logic f, input int exp_id, input logic exp_busy);
    logic [3:0] eg;
    logic [7:0] ed;
    logic [1:0] ei;
    req = r;
    fifo_full = f;
    eg = '0; ed = '0; ei = '0;
    if (exp_id >= 0) begin
      eg = 4'b0001 << exp_id;
      ed = 8'hA0 + 8'(exp_id);
      ei = 2'(exp_id);
    end
    @(negedge clk);
    check_eq($sformatf("c%0d_gnt", cyc), 32'(gnt), 32'(eg));
    check_eq($sformatf("c%0d_id", cyc), 32'(grant_id), 32'(ei));
    check_eq($sformatf("c%0d_wen", cyc), 32'(fifo_write_en), 32'(exp_id >= 0));
    check_eq($sformatf("c%0d_data", cyc), 32'(fifo_data_in), 32'(ed));
    check_eq($sformatf("c%0d_busy", cyc), 32'(busy), 32'(exp_busy));
    $display("cycle %0d req=%b full=%b gnt=%b id=%0d data=%h busy=%b",
             cyc, r, f, gnt, grant_id, fifo_data_in, busy);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse with all producers requesting: outputs must
  // clear before any clock edge.
  task automatic pulse_reset(input string tag);
    req = 4'b1111;
    fifo_full = 1'b0;
    #1 resetN = 1'b0;
    #1;
    check_eq({tag, "_gnt"}, 32'(gnt), 32'h0);
    check_eq({tag, "_wen"}, 32'(fifo_write_en), 32'h0);
    check_eq({tag, "_id"}, 32'(grant_id), 32'h0);
    check_eq({tag, "_data"}, 32'(fifo_data_in), 32'h0);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    $display("reset %s gnt=%b wen=%b busy=%b", tag, gnt, fifo_write_en, busy);
    @(posedge clk);
    #2 resetN = 1'b1;
  endtask

  initial begin
    pulse_reset("rst0");
`ifdef FIFO_ARB_LOCK_EN
    // Burst of 4 for producer 0, then 4 for producer 1, then back to 0.
    cycle(4'b0011, 0, 0, 0);
    cycle(4'b0011, 0, 0, 1);
    cycle(4'b0011, 0, 0, 1);
    cycle(4'b0011, 0, 0, 1);
    cycle(4'b0011, 0, 1, 0);
    cycle(4'b0011, 0, 1, 1);
    cycle(4'b0011, 0, 1, 1);
    cycle(4'b0011, 0, 1, 1);
    cycle(4'b0011, 0, 0, 0);
    // Producer 2 drops request after 2 beats; next arbitration starts at 3.
    pulse_reset("rst1");
    cycle(4'b0100, 0, 2, 0);
    cycle(4'b0100, 0, 2, 1);
    cycle(4'b0000, 0, -1, 1);
    cycle(4'b0000, 0, -1, 0);
    cycle(4'b1111, 0, 3, 0);
    // Producer 3 wins in the very cycle producer 2 drops (over producer 0).
    pulse_reset("rst2");
    cycle(4'b0100, 0, 2, 0);
    cycle(4'b0100, 0, 2, 1);
    cycle(4'b1001, 0, 3, 1);
    cycle(4'b1001, 0, 3, 1);
    // Mid-burst full for 5 cycles; burst then finishes its 2 remaining beats.
    pulse_reset("rst3");
    cycle(4'b0001, 0, 0, 0);
    cycle(4'b0001, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(4'b0011, 1, -1, 1);
    cycle(4'b0011, 0, 0, 1);
    cycle(4'b0011, 0, 0, 1);
    cycle(4'b0011, 0, 1, 0);
    // Reset in the middle of a burst (beat count 2), then restart at producer 0.
    pulse_reset("rst4");
    cycle(4'b1111, 0, 0, 0);
    cycle(4'b1111, 0, 0, 1);
    pulse_reset("rst5");
    cycle(4'b1111, 0, 0, 0);
    cycle(4'b1111, 0, 0, 1);
`else
    // Plain rotation with all producers requesting.
    cycle(4'b1111, 0, 0, 0);
    cycle(4'b1111, 0, 1, 0);
    cycle(4'b1111, 0, 2, 0);
    cycle(4'b1111, 0, 3, 0);
    cycle(4'b1111, 0, 0, 0);
    // Full FIFO blocks producer 2 and the pointer stays at 0; after the grant it is 3.
    pulse_reset("rst1");
    cycle(4'b0100, 1, -1, 0);
    cycle(4'b0100, 1, -1, 0);
    cycle(4'b0100, 1, -1, 0);
    cycle(4'b0100, 0, 2, 0);
    cycle(4'b1011, 0, 3, 0);
    cycle(4'b1011, 0, 0, 0);
    cycle(4'b1011, 0, 1, 0);
    cycle(4'b1011, 0, 3, 0);
    cycle(4'b0000, 0, -1, 0);
    cycle(4'b0110, 0, 1, 0);
    // Reset mid-traffic restarts arbitration at producer 0.
    pulse_reset("rst2");
    cycle(4'b1111, 0, 0, 0);
    cycle(4'b1111, 0, 1, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
